timer_arbiter: RTL and testbench
================================

# timer_arbiter

Round-robin scheduler that shares one `counter16` timeout counter among several tag-side requesters, such as the RX preamble watchdog, the T1 reply delay and the TX turnaround timer. A requester raises `req` with a cycle limit. The arbiter grants the counter, clears it, runs it until the count equals the limit, then pulses `done` to that requester. The block sits beside the `counter16` instance and drives that instance's `reset` and `enable` inputs.

## Interface
Parameters:
- `NREQ`, default 3: number of requesters.
- `SATMAX`, default 5001: highest value the counter can reach. The counter stops once `count > 5000`.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `req`  in  NREQ: level request per requester. Held high until `done` or an intentional abort.
- `req_limit`  in  16*NREQ: per-requester limit L. Slice i is bits [16i+15:16i]. Sampled only at grant.
- `count`  in  16: from `counter16.count`.
- `overflow`  in  1: from `counter16.overflow`.
- `cnt_clr`  out  1: registered. Drives `counter16.reset`.
- `cnt_en`  out  1: combinational. Drives `counter16.enable`.
- `grant`  out  NREQ: registered, one-hot or zero. Identifies the current owner.
- `done`  out  NREQ: registered, one-cycle one-hot pulse to the owner.
- `saturated`  out  1: registered. High together with `done` when the run ended with `overflow` set.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, CLEAR, RUN and DONE. Reset puts the FSM in IDLE.
- **IDLE**
  - If any `req` is high, select the winner by round-robin. The search starts at the index after the last grantee, wrapping modulo NREQ; the pointer resets to 0.
  - On selection: set `grant`, latch `lim = min(req_limit[winner], SATMAX)`, set `cnt_clr`, and go to CLEAR.
- **CLEAR**
  - `cnt_clr` is high for exactly this cycle, which forces count to 0.
  - Clear `cnt_clr` and go to RUN.
  - If the owner's `req` is low at this edge, abort: go to IDLE and clear `grant`.
- **RUN**
  - `cnt_en = (state==RUN) & (count != lim) & ~overflow` (combinational). The counter therefore stops exactly at `lim`.
  - When `count == lim` or `overflow` is high:
    - go to DONE;
    - set `done[owner]`;
    - set `saturated = overflow`;
    - advance the pointer to owner+1.
  - If the owner's `req` falls while in RUN: go to IDLE, clear `grant`, do not pulse `done`. The pointer still advances.
- **DONE**
  - `done` and `saturated` are high for this one cycle.
  - Next edge: clear `grant`, `done` and `saturated`, and go to IDLE.
  - A `req` still high in IDLE is re-arbitrated normally. Other requesters win first if they are pending.
- **Limit handling**
  - L = 0 is legal. RUN completes on its first cycle.
  - L > 5001 is clamped to 5001. The run ends on `overflow` with `saturated=1`.
- **Reset**
  - Reset clears all outputs to 0, state to IDLE and the pointer to 0, with immediate effect mid-run.
  - No `done` is pulsed for an interrupted run.

## Timing
- Reset values: `cnt_clr`=0, `cnt_en`=0, `grant`=0, `done`=0, `saturated`=0, `busy`=0.
- Sequence for a request sampled high in IDLE at edge E0:
  - E0: state becomes CLEAR; `grant` and `cnt_clr` go high.
  - E1: state becomes RUN; count is 0.
  - E1+k: count = k, for k ≤ L.
  - E1+L+1: state becomes DONE; `done` goes high.
  - E1+L+2: state becomes IDLE; `grant` goes low.
- `done` is therefore high for one cycle, L+2 cycles after the grant edge.
- Back-to-back service: with a second request pending, its CLEAR starts at E1+L+3. The gap is one IDLE cycle.
- Arbitration between requesters is evaluated only in IDLE.
- `req_limit` changes after grant are ignored.
- `count` and `overflow` are read only in RUN.

## Test plan
- **Single request:** `req`=001 with L=3. Expected: `grant`=001 at E0, `cnt_clr` high only in the CLEAR cycle, count runs 0,1,2,3 and holds at 3, `done`=001 exactly at E5, `saturated`=0, `busy` low at E6.
- **Zero limit:** `req[1]` with L=0. Expected: `done`=010 at E2, count stays 0, `cnt_en` never high.
- **Round-robin:** `req`=111 held, all L=2. Expected grant order 001, 010, 100, 001, with one IDLE cycle between runs. After reset, `req`=110 grants 010 first.
- **Clamp:** L=6000. Expected: count stops at 5001, `done` and `saturated`=1 together at E5003, `cnt_en` low from the edge where count reaches 5001.
- **Abort:** L=100, drop `req[0]` when count is 10. Expected: IDLE on the next edge, `grant`=0, no `done`, `cnt_en`=0; a pending `req[2]` is granted next.
- **Reset mid-run:** assert `reset` asynchronously when count is 50. Expected: all outputs 0 immediately, no `done`. After release, `req`=101 grants 001.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin owner selection for one shared counter16 timeout counter.
// Grants the counter, clears it, runs it to the owner's limit, then pulses done.
module timer_arbiter #(
  parameter int NREQ   = 3,
  parameter int SATMAX = 5001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_limit,
  input  logic [15:0]          count,
  input  logic                 overflow,
  output logic                 cnt_clr,
  output logic                 cnt_en,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 saturated,
  output logic                 busy
);

  localparam int          PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] SAT16 = 16'(SATMAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [15:0]       r_lim;
  logic              r_cnt_clr;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic              r_saturated;

  logic              w_found;
  logic [PW-1:0]     w_winner;
  logic [15:0]       w_raw_limit;
  logic [15:0]       w_win_limit;
  logic              w_owner_req;
  logic [PW-1:0]     w_next_ptr;

  // Search starts at r_ptr and wraps, so the first pending index found wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  assign w_raw_limit = req_limit[16*int'(w_winner) +: 16];
  assign w_win_limit = (w_raw_limit > SAT16) ? SAT16 : w_raw_limit;
  assign w_owner_req = req[r_owner];
  assign w_next_ptr  = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

  // The counter is enabled only while running and stops exactly at the limit.
  assign cnt_en    = (r_state == S_RUN) && (count != r_lim) && !overflow;
  assign busy      = (r_state != S_IDLE);
  assign cnt_clr   = r_cnt_clr;
  assign grant     = r_grant;
  assign done      = r_done;
  assign saturated = r_saturated;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_lim       <= '0;
      r_cnt_clr   <= 1'b0;
      r_grant     <= '0;
      r_done      <= '0;
      r_saturated <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= NREQ'(1) << w_winner;
            r_owner   <= w_winner;
            r_lim     <= w_win_limit;
            r_cnt_clr <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt_clr <= 1'b0;
          if (!w_owner_req) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // An abort wins over a same-cycle completion: no done for a dropped request.
          if (!w_owner_req) begin
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= S_IDLE;
          end else if ((count == r_lim) || overflow) begin
            r_done      <= r_grant;
            r_saturated <= overflow;
            r_ptr       <= w_next_ptr;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_grant     <= '0;
          r_done      <= '0;
          r_saturated <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural counter16 beside it.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_arbiter;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_limit;
  logic [15:0]       count = 16'd123;
  logic              overflow;
  logic              cnt_clr;
  logic              cnt_en;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              saturated;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  timer_arbiter #(.NREQ(NREQ), .SATMAX(5001)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_limit (req_limit),
    .count     (count),
    .overflow  (overflow),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .grant     (grant),
    .done      (done),
    .saturated (saturated),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // counter16 stand-in: synchronous clear, saturates once count exceeds 5000.
  always_ff @(posedge clk) begin
    if (cnt_clr) begin
      count <= 16'd0;
    end else if (cnt_en && (count <= 16'd5000)) begin
      count <= count + 16'd1;
    end
  end
  assign overflow = (count > 16'd5000);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   32'(grant),     32'h0);
    check({tag, "_done"},    32'(done),      32'h0);
    check({tag, "_sat"},     32'(saturated), 32'h0);
    check({tag, "_cnt_clr"}, 32'(cnt_clr),   32'h0);
    check({tag, "_cnt_en"},  32'(cnt_en),    32'h0);
    check({tag, "_busy"},    32'(busy),      32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_limit = '0;
    tick(2);
    check_all_zero("rst");
    reset = 1'b0;
    tick(1);

    // Single request, L=3: done lands at E5, idle again at E6.
    req       = 3'b001;
    req_limit = {16'd0, 16'd0, 16'd3};
    tick(1);
    check("s_grant_e0",  32'(grant),   32'h1);
    check("s_clr_e0",    32'(cnt_clr), 32'h1);
    check("s_en_e0",     32'(cnt_en),  32'h0);
    check("s_busy_e0",   32'(busy),    32'h1);
    tick(1);
    check("s_clr_e1",    32'(cnt_clr), 32'h0);
    check("s_cnt_e1",    32'(count),   32'd0);
    check("s_en_e1",     32'(cnt_en),  32'h1);
    tick(3);
    check("s_cnt_e4",    32'(count),   32'd3);
    check("s_en_e4",     32'(cnt_en),  32'h0);
    check("s_done_e4",   32'(done),    32'h0);
    tick(1);
    check("s_done_e5",   32'(done),    32'h1);
    check("s_sat_e5",    32'(saturated), 32'h0);
    check("s_cnt_e5",    32'(count),   32'd3);
    req = 3'b000;
    tick(1);
    check("s_busy_e6",   32'(busy),    32'h0);
    check("s_grant_e6",  32'(grant),   32'h0);
    check("s_done_e6",   32'(done),    32'h0);
    tick(1);

    // Zero limit on requester 1: done at E2, counter never enabled.
    req       = 3'b010;
    req_limit = {16'd9, 16'd0, 16'd9};
    tick(1);
    check("z_grant_e0",  32'(grant),   32'h2);
    check("z_en_e0",     32'(cnt_en),  32'h0);
    tick(1);
    check("z_cnt_e1",    32'(count),   32'd0);
    check("z_en_e1",     32'(cnt_en),  32'h0);
    tick(1);
    check("z_done_e2",   32'(done),    32'h2);
    check("z_cnt_e2",    32'(count),   32'd0);
    req = 3'b000;
    tick(2);

    // Round-robin with all three pending, L=2: one run every six edges.
    do_reset();
    req       = 3'b111;
    req_limit = {16'd2, 16'd2, 16'd2};
    tick(1);
    check("rr_grant_e0",  32'(grant), 32'h1);
    tick(4);
    check("rr_done_e4",   32'(done),  32'h1);
    tick(1);
    check("rr_grant_e5",  32'(grant), 32'h0);
    check("rr_busy_e5",   32'(busy),  32'h0);
    tick(1);
    check("rr_grant_e6",  32'(grant), 32'h2);
    tick(4);
    check("rr_done_e10",  32'(done),  32'h2);
    tick(2);
    check("rr_grant_e12", 32'(grant), 32'h4);
    tick(6);
    check("rr_grant_e18", 32'(grant), 32'h1);
    do_reset();
    req = 3'b110;
    tick(1);
    check("rr_rst_grant", 32'(grant), 32'h2);

    // Clamp: L=6000 becomes 5001; done with saturated at E5003.
    do_reset();
    req       = 3'b001;
    req_limit = {16'd0, 16'd0, 16'd6000};
    tick(1);
    check("c_grant_e0",    32'(grant),     32'h1);
    tick(5001);
    check("c_cnt_e5001",   32'(count),     32'd5000);
    check("c_en_e5001",    32'(cnt_en),    32'h1);
    tick(1);
    check("c_cnt_e5002",   32'(count),     32'd5001);
    check("c_en_e5002",    32'(cnt_en),    32'h0);
    check("c_done_e5002",  32'(done),      32'h0);
    tick(1);
    check("c_done_e5003",  32'(done),      32'h1);
    check("c_sat_e5003",   32'(saturated), 32'h1);
    check("c_cnt_e5003",   32'(count),     32'd5001);
    req = 3'b000;
    tick(1);
    check("c_sat_e5004",   32'(saturated), 32'h0);

    // Abort: drop req[0] at count 10; pending req[2] (L=1) is served next.
    do_reset();
    req       = 3'b101;
    req_limit = {16'd1, 16'd0, 16'd100};
    tick(1);
    check("a_grant_e0",   32'(grant),  32'h1);
    tick(11);
    check("a_cnt_e11",    32'(count),  32'd10);
    req = 3'b100;
    tick(1);
    check("a_grant_e12",  32'(grant),  32'h0);
    check("a_done_e12",   32'(done),   32'h0);
    check("a_en_e12",     32'(cnt_en), 32'h0);
    check("a_busy_e12",   32'(busy),   32'h0);
    tick(1);
    check("a_grant_e13",  32'(grant),  32'h4);
    tick(3);
    check("a_done_e16",   32'(done),   32'h4);
    req = 3'b000;
    tick(2);

    // Asynchronous reset at count 50 clears outputs before the next edge.
    do_reset();
    req       = 3'b001;
    req_limit = {16'd0, 16'd0, 16'd100};
    tick(52);
    check("r_cnt_e51",  32'(count),  32'd50);
    check("r_en_e51",   32'(cnt_en), 32'h1);
    #2 reset = 1'b1;
    #1 check_all_zero("r_async");
    tick(1);
    req       = 3'b101;
    req_limit = {16'd5, 16'd0, 16'd4};
    reset     = 1'b0;
    tick(1);
    check("r_grant_after", 32'(grant), 32'h1);
    check("r_done_after",  32'(done),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
